// File: rtl/nn_pkg.sv
// Shared fixed-point constants and deserializer state encoding for the network front end.
package nn_pkg;
    localparam int nnIntBits   = 6;
    localparam int nnFracBits  = 10;
    localparam int nnDataWidth = nnIntBits + nnFracBits;
    localparam int nnNumWords  = 784;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } deserState_e;
endpackage

// File: rtl/deser_frame_ctrl.sv
// Frame control for the input deserializer: state, word counter, handshake and per-slot write strobes.
// Framing check on inLast is compiled in only when DESER_FRAME_CHECK_EN is defined.
module deser_frame_ctrl
    import nn_pkg::*;
#(
    parameter int numWords     = nnNumWords,
    parameter int counterWidth = $clog2(numWords + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    input  logic                    inLast,
    input  logic                    outAck,
    output logic                    inReady,
    output logic                    layerOutValid,
    output logic                    frameError,
    output logic [counterWidth-1:0] wordCount,
    output logic [numWords-1:0]     slotWr
);
    deserState_e state, nextState;
    logic accept, lastIdx, earlyLast, missLast, frameBad;

    assign accept  = inValid && inReady;
    assign lastIdx = (wordCount == counterWidth'(numWords - 1));

`ifdef DESER_FRAME_CHECK_EN
    assign earlyLast = accept && inLast && !lastIdx;
    assign missLast  = accept && !inLast && lastIdx;
`else
    logic unusedLast;
    assign unusedLast = inLast;
    assign earlyLast  = 1'b0;
    assign missLast   = 1'b0;
`endif
    assign frameBad = earlyLast || missLast;

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FILL:    if (accept && lastIdx && !missLast) nextState = DONE;
            DONE:    if (outAck) nextState = FILL;
            default: nextState = FILL;
        endcase
    end

    always_comb begin
        inReady       = (state == FILL);
        layerOutValid = (state == DONE);
    end

    // A dropped frame restarts at slot 0; a good final beat parks the count at numWords.
    always_ff @(posedge clk) begin
        if (reset)                        wordCount <= '0;
        else if (state == DONE && outAck) wordCount <= '0;
        else if (frameBad)                wordCount <= '0;
        else if (accept)                  wordCount <= wordCount + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) frameError <= 1'b0;
        else       frameError <= frameBad;
    end

    for (genvar k = 0; k < numWords; k++) begin : gSlotWr
        assign slotWr[k] = accept && (wordCount == counterWidth'(k));
    end
endmodule

// File: rtl/input_deserializer.sv
// Packs a valid/ready word stream into the flat frame vector for the first layer; holds it until outAck.
// Optional inLast framing check is enabled by DESER_FRAME_CHECK_EN.
module input_deserializer
    import nn_pkg::*;
#(
    parameter int numWords     = nnNumWords,
    parameter int dataWidth    = nnDataWidth,
    parameter int counterWidth = $clog2(numWords + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [dataWidth-1:0]          inData,
    input  logic                          inValid,
    input  logic                          inLast,
    output logic                          inReady,
    input  logic                          outAck,
    output logic [dataWidth*numWords-1:0] layerOut,
    output logic                          layerOutValid,
    output logic [counterWidth-1:0]       wordCount,
    output logic                          frameError
);
    logic [numWords-1:0]                slotWr;
    logic [numWords-1:0][dataWidth-1:0] slots;

    deser_frame_ctrl #(
        .numWords     (numWords),
        .counterWidth (counterWidth)
    ) uCtrl (
        .clk           (clk),
        .reset         (reset),
        .inValid       (inValid),
        .inLast        (inLast),
        .outAck        (outAck),
        .inReady       (inReady),
        .layerOutValid (layerOutValid),
        .frameError    (frameError),
        .wordCount     (wordCount),
        .slotWr        (slotWr)
    );

    // Slots keep stale data after outAck until the next frame overwrites them.
    for (genvar k = 0; k < numWords; k++) begin : gSlot
        always_ff @(posedge clk) begin
            if (reset)          slots[k] <= '0;
            else if (slotWr[k]) slots[k] <= inData;
        end
    end

    assign layerOut = slots;
endmodule

// File: tb/tb_input_deserializer.sv
// Directed bench for input_deserializer: small 4-word instance with a word scoreboard plus a full 784-word instance.
module tb_input_deserializer;
    localparam int NW = 4, DW = 16, CW = 3;
    localparam int BW = 784, BCW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, inValid, inLast, outAck, inReady, layerOutValid, frameError;
    logic [DW-1:0]    inData;
    logic [DW*NW-1:0] layerOut;
    logic [CW-1:0]    wordCount;

    logic bValid, bLast, bAck, bReady, bOutValid, bErr;
    logic [DW-1:0]    bData;
    logic [DW*BW-1:0] bOut;
    logic [BCW-1:0]   bCount;

    int total = 0, bad = 0;
    int bRise = 0;
    logic bValidQ = 1'b0;
    logic [DW-1:0] expQ[$];
    logic [DW*NW-1:0] held;

    input_deserializer #(.numWords(NW), .dataWidth(DW)) dut (
        .clk(clk), .reset(reset), .inData(inData), .inValid(inValid), .inLast(inLast),
        .inReady(inReady), .outAck(outAck), .layerOut(layerOut), .layerOutValid(layerOutValid),
        .wordCount(wordCount), .frameError(frameError));

    input_deserializer #(.numWords(BW), .dataWidth(DW)) dutBig (
        .clk(clk), .reset(reset), .inData(bData), .inValid(bValid), .inLast(bLast),
        .inReady(bReady), .outAck(bAck), .layerOut(bOut), .layerOutValid(bOutValid),
        .wordCount(bCount), .frameError(bErr));

    always @(posedge clk) begin
        if (bOutValid && !bValidQ) bRise <= bRise + 1;
        bValidQ <= bOutValid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w, input logic last);
        int n = 0;
        inData = w; inValid = 1'b1; inLast = last;
        while (!inReady && n < 50) begin tick(); n++; end
        check("send_ready", 64'(inReady), 64'd1);
        expQ.push_back(w);
        tick();
        inValid = 1'b0; inLast = 1'b0;
    endtask

    task automatic checkFrame(input string tag);
        logic [DW-1:0] w;
        check({tag, "_valid"}, 64'(layerOutValid), 64'd1);
        check({tag, "_ready"}, 64'(inReady), 64'd0);
        check({tag, "_count"}, 64'(wordCount), 64'(NW));
        for (int k = 0; k < NW; k++) begin
            check({tag, "_sb_nonempty"}, 64'(expQ.size() != 0), 64'd1);
            w = (expQ.size() != 0) ? expQ.pop_front() : '0;
            check({tag, "_word"}, 64'(layerOut[k*DW +: DW]), 64'(w));
        end
    endtask

    task automatic ack();
        outAck = 1'b1;
        tick();
        outAck = 1'b0;
        check("ack_valid", 64'(layerOutValid), 64'd0);
        check("ack_count", 64'(wordCount), 64'd0);
        check("ack_ready", 64'(inReady), 64'd1);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inLast = 1'b0; outAck = 1'b0; inData = '0;
        bValid = 1'b0; bLast = 1'b0; bAck = 1'b0; bData = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_ready", 64'(inReady), 64'd1);
        check("rst_valid", 64'(layerOutValid), 64'd0);
        check("rst_count", 64'(wordCount), 64'd0);
        check("rst_out", layerOut, 64'd0);
        check("rst_err", 64'(frameError), 64'd0);
        check("rst_big_ready", 64'(bReady), 64'd1);

        // basic back-to-back frame
        send(16'h0001, 1'b0); send(16'h0002, 1'b0); send(16'h0003, 1'b0); send(16'h0004, 1'b1);
        check("basic_packed", layerOut, 64'h0004_0003_0002_0001);
        checkFrame("basic");
        check("basic_err", 64'(frameError), 64'd0);

        // backpressure while DONE
        held = layerOut;
        inData = 16'hFFFF; inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out", layerOut, held);
            check("bp_count", 64'(wordCount), 64'(NW));
            check("bp_ready", 64'(inReady), 64'd0);
        end
        outAck = 1'b1;
        tick();
        outAck = 1'b0;
        check("bp_ack_count", 64'(wordCount), 64'd0);
        check("bp_ack_ready", 64'(inReady), 64'd1);
        expQ.push_back(16'hFFFF);
        tick();
        inValid = 1'b0;
        check("bp_first_count", 64'(wordCount), 64'd1);
        check("bp_stale_out", layerOut, 64'h0004_0003_0002_FFFF);
        send(16'h1111, 1'b0); send(16'h2222, 1'b0); send(16'h3333, 1'b1);
        checkFrame("bp_frame");
        ack();

        // random bubbles between words
        for (int i = 0; i < NW; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            check("gap_count_hold", 64'(wordCount), 64'(i));
            send(DW'(i + 1), i == NW - 1);
            check("gap_count", 64'(wordCount), 64'(i + 1));
        end
        check("gap_packed", layerOut, 64'h0004_0003_0002_0001);
        checkFrame("gap");
        ack();

        // reset mid-frame
        send(16'hBEEF, 1'b0); send(16'hCAFE, 1'b0);
        check("mid_count", 64'(wordCount), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expQ.delete();
        check("mid_rst_count", 64'(wordCount), 64'd0);
        check("mid_rst_out", layerOut, 64'd0);
        check("mid_rst_valid", 64'(layerOutValid), 64'd0);
        send(16'h000A, 1'b0); send(16'h000B, 1'b0); send(16'h000C, 1'b0); send(16'h000D, 1'b1);
        check("mid_packed", layerOut, 64'h000D_000C_000B_000A);
        checkFrame("mid");
        ack();

`ifdef DESER_FRAME_CHECK_EN
        send(16'h0100, 1'b0); send(16'h0200, 1'b1);
        check("early_err", 64'(frameError), 64'd1);
        check("early_count", 64'(wordCount), 64'd0);
        check("early_valid", 64'(layerOutValid), 64'd0);
        tick();
        check("early_err_pulse", 64'(frameError), 64'd0);
        expQ.delete();
        for (int i = 0; i < NW; i++) send(DW'(16'h0300 + i), 1'b0);
        check("miss_err", 64'(frameError), 64'd1);
        check("miss_valid", 64'(layerOutValid), 64'd0);
        check("miss_count", 64'(wordCount), 64'd0);
        check("miss_ready", 64'(inReady), 64'd1);
        tick();
        check("miss_err_pulse", 64'(frameError), 64'd0);
        check("miss_valid_hold", 64'(layerOutValid), 64'd0);
        expQ.delete();
`else
        // inLast has no effect; the count alone closes the frame
        send(16'h0100, 1'b1);
        check("nolast_count", 64'(wordCount), 64'd1);
        check("nolast_err", 64'(frameError), 64'd0);
        send(16'h0200, 1'b0); send(16'h0300, 1'b0); send(16'h0400, 1'b0);
        checkFrame("nolast");
        check("nolast_err2", 64'(frameError), 64'd0);
        ack();
`endif

        // full-size frame
        for (int k = 0; k < BW; k++) begin
            bData = DW'(k); bValid = 1'b1; bLast = (k == BW - 1);
            check("big_ready", 64'(bReady), 64'd1);
            check("big_valid_low", 64'(bOutValid), 64'd0);
            tick();
        end
        bValid = 1'b0; bLast = 1'b0;
        check("big_valid", 64'(bOutValid), 64'd1);
        check("big_count", 64'(bCount), 64'(BW));
        check("big_err", 64'(bErr), 64'd0);
        for (int k = 0; k < BW; k++) check("big_word", 64'(bOut[k*DW +: DW]), 64'(k));
        tick(); tick();
        bAck = 1'b1;
        tick();
        bAck = 1'b0;
        tick(); tick();
        check("big_valid_after_ack", 64'(bOutValid), 64'd0);
        check("big_rise_once", 64'(bRise), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
